// File: rtl/cnt_sched_arbiter_if.sv
// cnt_sched_arbiter_if: request/grant bus and counter-datapath control bundle for the scheduler.
interface cnt_sched_arbiter_if;
    logic [1:0] req;
    logic [1:0] op0;
    logic [7:0] arg0;
    logic [1:0] op1;
    logic [7:0] arg1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       cnt_inc;
    logic       cnt_load;
    logic [7:0] cnt_load_val;
    logic       cnt_oe;
    logic [7:0] cnt_value;
    logic [7:0] rd_data;
    modport master (
        output req, op0, arg0, op1, arg1, cnt_value,
        input  gnt, done, busy, cnt_inc, cnt_load, cnt_load_val, cnt_oe, rd_data
    );
    modport slave (
        input  req, op0, arg0, op1, arg1, cnt_value,
        output gnt, done, busy, cnt_inc, cnt_load, cnt_load_val, cnt_oe, rd_data
    );
endinterface

// File: rtl/cnt_sched_arbiter.sv
// cnt_sched_arbiter: round-robin two-requester scheduler sequencing a shared 8-bit counter datapath.
// Optional CNT_SCHED_ABORT_EN: granted requester dropping req ends a COUNT/READ early.
module cnt_sched_arbiter #(
    parameter int OE_CYCLES = 2,
    parameter bit RR_INIT   = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    cnt_sched_arbiter_if.slave bus_if
);
    typedef enum logic [1:0] {IDLE, GRANT, EXEC, DONE} state_t;
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_COUNT = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       win_q, win_d;
    logic [1:0] op_q, op_d;
    logic [7:0] arg_q, arg_d;
    logic [7:0] len_q, len_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [1:0] op_sel;
    logic [7:0] arg_sel;
    logic       abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= RR_INIT;
            win_q     <= 1'b0;
            op_q      <= OP_NOP;
            arg_q     <= 8'd0;
            len_q     <= 8'd0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            rd_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            op_q      <= op_d;
            arg_q     <= arg_d;
            len_q     <= len_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        op_sel    = win_q ? bus_if.op1 : bus_if.op0;
        arg_sel   = win_q ? bus_if.arg1 : bus_if.arg0;
`ifdef CNT_SCHED_ABORT_EN
        abort     = op_q[1] && !bus_if.req[win_q];
`else
        abort     = 1'b0;
`endif
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        op_d      = op_q;
        arg_d     = arg_q;
        len_d     = len_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (bus_if.req != 2'b00) begin
                    state_d = GRANT;
                    win_d   = (bus_if.req == 2'b11) ? ptr_q : bus_if.req[1];
                end
            end
            GRANT: begin
                op_d    = op_sel;
                arg_d   = arg_sel;
                // len_d is the number of EXEC cycles; zero skips EXEC entirely
                len_d   = (op_sel == OP_LOAD)  ? 8'd1 :
                          (op_sel == OP_COUNT) ? arg_sel :
                          (op_sel == OP_READ)  ? 8'(OE_CYCLES) : 8'd0;
                state_d = (len_d == 8'd0) ? DONE : EXEC;
            end
            EXEC: begin
                len_d = len_q - 8'd1;
                if (abort) begin
                    state_d = DONE;
                end else if (len_q == 8'd1) begin
                    state_d = DONE;
                    if (op_q == OP_READ) rd_data_d = bus_if.cnt_value;
                end
            end
            DONE: begin
                ptr_d   = ~win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        gnt_d  = (state_d == IDLE) ? 2'b00 : (win_d ? 2'b10 : 2'b01);
        done_d = (state_d == DONE) ? gnt_d : 2'b00;
    end

    // strobes decode from flopped state so reset clears them asynchronously
    always_comb begin
        bus_if.cnt_inc      = (state_q == EXEC) && (op_q == OP_COUNT);
        bus_if.cnt_load     = (state_q == EXEC) && (op_q == OP_LOAD);
        bus_if.cnt_oe       = (state_q == EXEC) && (op_q == OP_READ);
        bus_if.cnt_load_val = bus_if.cnt_load ? arg_q : 8'd0;
        bus_if.busy         = state_q != IDLE;
        bus_if.gnt          = gnt_q;
        bus_if.done         = done_q;
        bus_if.rd_data      = rd_data_q;
    end
endmodule

// File: tb/tb_cnt_sched_arbiter.sv
// tb_cnt_sched_arbiter: directed bench with a timeline model of per-cycle expected outputs.
module tb_cnt_sched_arbiter;
    localparam int OE = 2;
    localparam bit RR = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnt_sched_arbiter_if bus();
    cnt_sched_arbiter #(.OE_CYCLES(OE), .RR_INIT(RR)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] done;
        logic       busy;
        logic       inc;
        logic       load;
        logic       oe;
        logic [7:0] lval;
        logic       rd_last;
        logic       abortable;
    } exp_t;

    // Each accepted request expands into its full expected timeline: GRANT, n EXEC cycles, DONE
    exp_t       mq[$];
    exp_t       cur;
    exp_t       e;
    logic       ptr_m;
    logic [7:0] rd_m;
    logic       w;
    logic       ab;
    logic [1:0] o;
    logic [7:0] a;
    int         n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            cur   = '0;
            ptr_m = RR;
            rd_m  = 8'd0;
        end else begin
            ab = 1'b0;
`ifdef CNT_SCHED_ABORT_EN
            if (cur.abortable && (bus.req & cur.gnt) == 2'b00) begin
                ab = 1'b1;
                mq.delete();
                e = '0;
                e.gnt = cur.gnt;
                e.done = cur.gnt;
                e.busy = 1'b1;
                mq.push_back(e);
            end
`endif
            if (cur.rd_last && !ab) rd_m = bus.cnt_value;
            if (!cur.busy && bus.req != 2'b00) begin
                w = (bus.req == 2'b11) ? ptr_m : bus.req[1];
                ptr_m = ~w;
                o = w ? bus.op1 : bus.op0;
                a = w ? bus.arg1 : bus.arg0;
                n = (o == 2'd1) ? 1 : (o == 2'd2) ? int'(a) : (o == 2'd3) ? OE : 0;
                e = '0;
                e.gnt = w ? 2'b10 : 2'b01;
                e.busy = 1'b1;
                mq.push_back(e);
                for (int i = 0; i < n; i++) begin
                    e.inc = (o == 2'd2);
                    e.load = (o == 2'd1);
                    e.oe = (o == 2'd3);
                    e.lval = (o == 2'd1) ? a : 8'd0;
                    e.rd_last = (o == 2'd3) && (i == n - 1);
                    e.abortable = o[1];
                    mq.push_back(e);
                end
                e.inc = 1'b0;
                e.load = 1'b0;
                e.oe = 1'b0;
                e.lval = 8'd0;
                e.rd_last = 1'b0;
                e.abortable = 1'b0;
                e.done = e.gnt;
                mq.push_back(e);
            end
            if (mq.size() > 0) cur = mq.pop_front();
            else cur = '0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if ({bus.gnt, bus.done, bus.busy, bus.cnt_inc, bus.cnt_load, bus.cnt_oe, bus.cnt_load_val} !==
                {cur.gnt, cur.done, cur.busy, cur.inc, cur.load, cur.oe, cur.lval}) begin
                fails++;
                $display("FAIL model_outputs cyc=%0d got gnt=%b done=%b busy=%b inc=%b load=%b oe=%b lval=%h exp gnt=%b done=%b busy=%b inc=%b load=%b oe=%b lval=%h",
                         cyc, bus.gnt, bus.done, bus.busy, bus.cnt_inc, bus.cnt_load, bus.cnt_oe, bus.cnt_load_val,
                         cur.gnt, cur.done, cur.busy, cur.inc, cur.load, cur.oe, cur.lval);
            end
            tests++;
            if (bus.rd_data !== rd_m) begin
                fails++;
                $display("FAIL model_rd_data cyc=%0d got %h exp %h", cyc, bus.rd_data, rd_m);
            end
        end
    end

    // Event recorder for the hand-computed latency checks
    int         t0, gnt_cyc, load_cyc, done_cyc, first_inc, last_inc;
    int         inc_cnt, oe_cnt, done_cnt;
    logic [1:0] gnt_val, gnt_prev = 2'b00;
    logic [7:0] load_val;
    logic [1:0] glog[$];

    always @(negedge clk) begin
        if (bus.gnt != 2'b00 && gnt_prev == 2'b00) begin
            gnt_cyc = cyc;
            gnt_val = bus.gnt;
            glog.push_back(bus.gnt);
        end
        gnt_prev = bus.gnt;
        if (bus.cnt_load) begin
            load_cyc = cyc;
            load_val = bus.cnt_load_val;
        end
        if (bus.cnt_inc) begin
            if (inc_cnt == 0) first_inc = cyc;
            last_inc = cyc;
            inc_cnt++;
        end
        if (bus.cnt_oe) oe_cnt++;
        if (bus.done != 2'b00) begin
            done_cyc = cyc;
            done_cnt++;
        end
    end

    task automatic chk(input string nm, input int got, input int expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s got %0d exp %0d", nm, got, expv);
        end
    endtask

    task automatic start(input int r, input logic [1:0] op, input logic [7:0] arg);
        @(posedge clk);
        #1;
        if (r == 0) begin
            bus.op0 = op;
            bus.arg0 = arg;
        end else begin
            bus.op1 = op;
            bus.arg1 = arg;
        end
        bus.req[r] = 1'b1;
        t0 = cyc;
        inc_cnt = 0;
        oe_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        load_cyc = -1;
        gnt_cyc = -1;
    endtask

    task automatic finish_op(input int r, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done[r];
        end
        chk({nm, "_done_seen"}, int'(seen), 1);
        @(posedge clk);
        #1;
        bus.req[r] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.req = 2'b00;
        bus.op0 = 2'b00;
        bus.arg0 = 8'd0;
        bus.op1 = 2'b00;
        bus.arg1 = 8'd0;
        bus.cnt_value = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", int'({bus.gnt, bus.done, bus.busy, bus.cnt_inc, bus.cnt_load, bus.cnt_oe}), 0);
        chk("reset_rd_data", int'(bus.rd_data), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        start(0, 2'b01, 8'h5A);
        finish_op(0, "load");
        chk("load_gnt_lat", gnt_cyc - t0, 1);
        chk("load_gnt_val", int'(gnt_val), 1);
        chk("load_strobe_lat", load_cyc - t0, 2);
        chk("load_val", int'(load_val), 'h5A);
        chk("load_done_lat", done_cyc - t0, 3);
        chk("load_busy_after", int'(bus.busy), 0);

        start(1, 2'b10, 8'd5);
        finish_op(1, "count5");
        chk("count5_inc_cycles", inc_cnt, 5);
        chk("count5_inc_consecutive", last_inc - first_inc, 4);
        chk("count5_done_after_inc", done_cyc - last_inc, 1);

        start(0, 2'b10, 8'd0);
        finish_op(0, "count0");
        chk("count0_inc_cycles", inc_cnt, 0);
        chk("count0_done_lat", done_cyc - t0, 2);

        bus.cnt_value = 8'h11;
        start(1, 2'b11, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1 bus.cnt_value = 8'h33;
        @(posedge clk);
        #1 bus.cnt_value = 8'h34;
        finish_op(1, "read");
        bus.cnt_value = 8'h99;
        chk("read_oe_cycles", oe_cnt, OE);
        chk("read_rd_data", int'(bus.rd_data), 'h34);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("reset_clears_rd_data", int'(bus.rd_data), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        glog.delete();
        bus.op0 = 2'b00;
        bus.op1 = 2'b00;
        @(posedge clk);
        #1 bus.req = 2'b11;
        for (int i = 0; i < 60 && glog.size() < 4; i++) begin
            @(negedge clk);
            #1;
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = |bus.done;
        end
        chk("rr_last_done_seen", int'(seen), 1);
        @(posedge clk);
        #1 bus.req = 2'b00;
        repeat (4) @(posedge clk);
        chk("rr_grant_count", glog.size(), 4);
        if (glog.size() >= 4) begin
            chk("rr_grant0", int'(glog[0]), 1);
            chk("rr_grant1", int'(glog[1]), 2);
            chk("rr_grant2", int'(glog[2]), 1);
            chk("rr_grant3", int'(glog[3]), 2);
        end

        start(0, 2'b10, 8'd200);
        repeat (10) @(posedge clk);
        #3 chk("count200_running", int'(bus.cnt_inc), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_reset_strobes", int'({bus.cnt_inc, bus.cnt_load, bus.cnt_oe}), 0);
        chk("abort_reset_gnt", int'(bus.gnt), 0);
        chk("abort_reset_busy", int'(bus.busy), 0);
        bus.req = 2'b00;
        done_cnt = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        chk("abort_reset_no_done", done_cnt, 0);

`ifdef CNT_SCHED_ABORT_EN
        start(1, 2'b10, 8'd50);
        repeat (5) @(posedge clk);
        #1 bus.req[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done[1];
        end
        chk("req_drop_done_seen", int'(seen), 1);
        chk("req_drop_inc_cycles", inc_cnt, 4);
        repeat (3) @(posedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
